// File: rtl/apb_regfile_gen.sv
// Parametrised APB3 slave register file with per-register access modes,
// byte strobes, programmable wait states, address-decode errors and an interrupt.
module apb_regfile_gen #(
  parameter int unsigned                  ADDR_W      = 8,
  parameter int unsigned                  DATA_W      = 32,
  parameter int unsigned                  NUM_REGS    = 8,
  parameter int unsigned                  WAIT_STATES = 0,
  parameter logic [NUM_REGS*3-1:0]        REG_MODES   = '0,
  parameter logic [NUM_REGS*DATA_W-1:0]   RESET_VALS  = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_W-1:0]          paddr,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [DATA_W-1:0]          pwdata,
  input  logic [DATA_W/8-1:0]        pstrb,
  output logic [DATA_W-1:0]          prdata,
  output logic                       pready,
  output logic                       pslverr,
  input  logic [NUM_REGS*DATA_W-1:0] hw_in,
  input  logic [NUM_REGS*DATA_W-1:0] hw_set,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  output logic                       irq
);

  localparam int unsigned IDX_W  = ADDR_W - 2;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;
  typedef enum logic [2:0] {
    MODE_RW  = 3'd0,
    MODE_RO  = 3'd1,
    MODE_W1C = 3'd2,
    MODE_W1S = 3'd3,
    MODE_WO  = 3'd4,
    MODE_RC  = 3'd5
  } mode_e;

  function automatic mode_e mode_of(input int unsigned i);
    return mode_e'(REG_MODES[i*3 +: 3]);
  endfunction

  state_e                           state_q, state_d;
  logic [3:0]                       cnt_q, cnt_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_q, regs_d;
  logic [IDX_W-1:0]                 idx;
  logic [NUM_REGS-1:0]              sel_vec, sel_q;
  mode_e                            sel_mode;
  logic [DATA_W-1:0]                rd_val;
  logic [DATA_W-1:0]                lane_mask;
  logic                             bad;
  logic                             enter_ack;
  logic                             wr_q, err_q;
  logic                             commit_wr, commit_rd;
  logic                             irq_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (psel && !penable) begin
          if (WAIT_STATES == 0) begin
            state_d = S_ACK;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (!psel) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign enter_ack = (state_d == S_ACK);
  assign idx       = paddr[ADDR_W-1:2];

  // One-hot select instead of a variable index keeps out-of-range idx harmless.
  always_comb begin
    sel_vec  = '0;
    sel_mode = MODE_RW;
    rd_val   = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (32'(idx) == i) begin
        sel_vec[i] = 1'b1;
        sel_mode   = mode_of(i);
        case (mode_of(i))
          MODE_RO: rd_val = hw_in[i*DATA_W +: DATA_W];
          MODE_WO: rd_val = '0;
          default: rd_val = regs_q[i];
        endcase
      end
    end
  end

  assign bad = (sel_vec == '0) || (paddr[1:0] != 2'b00) ||
               (pwrite && (sel_mode == MODE_RO));

  always_comb begin
    lane_mask = '0;
    for (int unsigned b = 0; b < STRB_W; b++) begin
      lane_mask[b*8 +: 8] = {8{pstrb[b]}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prdata  <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= '0;
    end else begin
      pready  <= enter_ack;
      pslverr <= enter_ack && bad;
      if (enter_ack) begin
        prdata <= (bad || pwrite) ? '0 : rd_val;
        wr_q   <= pwrite;
        err_q  <= bad;
        sel_q  <= sel_vec;
      end
    end
  end

  assign commit_wr = (state_q == S_ACK) && wr_q && !err_q;
  assign commit_rd = (state_q == S_ACK) && !wr_q && !err_q;

  // hw_set is OR-ed in after the software update so it wins on the same bit.
  always_comb begin
    regs_d = regs_q;
    irq_d  = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      case (mode_of(i))
        MODE_RW, MODE_WO: begin
          if (commit_wr && sel_q[i])
            regs_d[i] = (regs_q[i] & ~lane_mask) | (pwdata & lane_mask);
        end
        MODE_W1S: begin
          if (commit_wr && sel_q[i])
            regs_d[i] = regs_q[i] | (pwdata & lane_mask);
        end
        MODE_W1C: begin
          if (commit_wr && sel_q[i])
            regs_d[i] = regs_q[i] & ~(pwdata & lane_mask);
          regs_d[i] = regs_d[i] | hw_set[i*DATA_W +: DATA_W];
          irq_d     = irq_d | (|regs_q[i]);
        end
        MODE_RC: begin
          if (commit_rd && sel_q[i])
            regs_d[i] = regs_q[i] & ~prdata;
          regs_d[i] = regs_d[i] | hw_set[i*DATA_W +: DATA_W];
          irq_d     = irq_d | (|regs_q[i]);
        end
        default: regs_d[i] = regs_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= RESET_VALS;
      irq    <= 1'b0;
    end else begin
      regs_q <= regs_d;
      irq    <= irq_d;
    end
  end

  assign reg_out = regs_q;

endmodule

// File: tb/tb_apb_regfile_gen.sv
// Scoreboard bench: two instances (0 and 3 wait states) sharing the APB bus with
// separate selects; a negedge monitor checks each pready against queued expectations.
module tb_apb_regfile_gen;

  localparam logic [23:0]  MODES = {3'd0, 3'd4, 3'd3, 3'd1, 3'd5, 3'd2, 3'd0, 3'd0};
  localparam logic [255:0] RV    = {32'h0, 32'h0, 32'h0, 32'h0,
                                    32'h0, 32'h0, 32'h1234_5678, 32'h0};

  logic         clk, rst_n;
  logic [7:0]   paddr;
  logic         psel0, psel3, penable, pwrite;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [31:0]  prdata0, prdata3;
  logic         pready0, pready3, pslverr0, pslverr3, irq0, irq3;
  logic [255:0] hw_in0, hw_in3, hw_set0, hw_set3, reg_out0, reg_out3;

  typedef struct {
    string       name;
    bit          d3;
    logic [31:0] rd;
    bit          err;
    int          lat;
    int          start;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  apb_regfile_gen #(.ADDR_W(8), .DATA_W(32), .NUM_REGS(8), .WAIT_STATES(0),
                    .REG_MODES(MODES), .RESET_VALS(RV)) u0 (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel0), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata0),
    .pready(pready0), .pslverr(pslverr0), .hw_in(hw_in0), .hw_set(hw_set0),
    .reg_out(reg_out0), .irq(irq0));

  apb_regfile_gen #(.ADDR_W(8), .DATA_W(32), .NUM_REGS(8), .WAIT_STATES(3),
                    .REG_MODES(MODES), .RESET_VALS(RV)) u3 (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel3), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata3),
    .pready(pready3), .pslverr(pslverr3), .hw_in(hw_in3), .hw_set(hw_set3),
    .reg_out(reg_out3), .irq(irq3));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r0(input int i);
    return reg_out0[i*32 +: 32];
  endfunction

  function automatic logic [31:0] r3(input int i);
    return reg_out3[i*32 +: 32];
  endfunction

  task automatic rsp(input bit d3, input logic [31:0] rd, input logic err);
    exp_t e;
    if (q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_pready: got pready on dut%0d expected none", d3 ? 3 : 0);
      return;
    end
    e = q.pop_front();
    cmp({e.name, "_dut"},     256'(d3),        256'(e.d3));
    cmp({e.name, "_prdata"},  256'(rd),        256'(e.rd));
    cmp({e.name, "_pslverr"}, 256'(err),       256'(e.err));
    cmp({e.name, "_latency"}, 256'(cyc - e.start), 256'(e.lat));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (pready0) rsp(1'b0, prdata0, pslverr0);
      if (pready3) rsp(1'b1, prdata3, pslverr3);
    end
  end

  // Called #1 after a clock edge; returns #1 after the edge that ends ACK.
  task automatic apb(input bit d3, input bit wr, input logic [7:0] addr,
                     input logic [31:0] wd, input logic [3:0] st,
                     input int hs_reg, input logic [31:0] hs,
                     input logic [31:0] exp_rd, input bit exp_err, input string name);
    exp_t e;
    int   n;
    paddr = addr; pwrite = wr; pwdata = wd; pstrb = st; penable = 1'b0;
    if (d3) psel3 = 1'b1; else psel0 = 1'b1;
    e.name = name; e.d3 = d3; e.rd = exp_rd; e.err = exp_err;
    e.lat = d3 ? 4 : 1; e.start = cyc;
    q.push_back(e);
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    while (!(d3 ? pready3 : pready0) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no pready after %0d cycles expected pready", name, n);
    end
    if (d3) hw_set3[hs_reg*32 +: 32] = hs;
    else    hw_set0[hs_reg*32 +: 32] = hs;
    @(posedge clk); #1;
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    hw_set0 = '0; hw_set3 = '0;
  endtask

  task automatic pulse0(input int r, input logic [31:0] v);
    hw_set0[r*32 +: 32] = v;
    @(posedge clk); #1;
    hw_set0 = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; paddr = '0; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    pwrite = 1'b0; pwdata = '0; pstrb = '0;
    hw_in0 = '0; hw_in3 = '0; hw_set0 = '0; hw_set3 = '0;
    hw_in0[4*32 +: 32] = 32'hCAFE_F00D;
    repeat (3) @(posedge clk);
    #1;
    cmp("rst_prdata0", 256'(prdata0), 256'h0);
    cmp("rst_pready0", 256'(pready0), 256'h0);
    cmp("rst_pslverr0", 256'(pslverr0), 256'h0);
    cmp("rst_irq0", 256'(irq0), 256'h0);
    cmp("rst_regs0", reg_out0, RV);
    cmp("rst_regs3", reg_out3, RV);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero wait states: RW, byte strobes
    apb(0, 1, 8'h00, 32'hA5A5_5A5A, 4'hF, 0, 0, 32'h0, 0, "wr_reg0");
    apb(0, 0, 8'h00, 32'h0, 4'h0, 0, 0, 32'hA5A5_5A5A, 0, "rd_reg0");
    cmp("reg0_out", 256'(r0(0)), 256'hA5A5_5A5A);
    apb(0, 1, 8'h04, 32'h0000_FF00, 4'b0010, 0, 0, 32'h0, 0, "wr_strb");
    cmp("reg1_strb", 256'(r0(1)), 256'h1234_FF78);
    apb(0, 0, 8'h04, 32'h0, 4'h0, 0, 0, 32'h1234_FF78, 0, "rd_strb");

    // W1C with hw_set and irq timing
    pulse0(2, 32'h8);
    cmp("w1c_set", 256'(r0(2)), 256'h8);
    cmp("irq_lag", 256'(irq0), 256'h0);
    @(posedge clk); #1;
    cmp("irq_set", 256'(irq0), 256'h1);
    apb(0, 1, 8'h08, 32'h8, 4'hF, 2, 32'h8, 32'h0, 0, "w1c_race");
    cmp("w1c_hw_wins", 256'(r0(2)), 256'h8);
    apb(0, 1, 8'h08, 32'h8, 4'hF, 0, 0, 32'h0, 0, "w1c_clr");
    cmp("w1c_cleared", 256'(r0(2)), 256'h0);
    @(posedge clk); #1;
    cmp("irq_clr", 256'(irq0), 256'h0);

    // Read-clear with hw_set during ACK
    pulse0(3, 32'h5);
    apb(0, 0, 8'h0C, 32'h0, 4'h0, 3, 32'h2, 32'h5, 0, "rc_rd1");
    cmp("rc_after1", 256'(r0(3)), 256'h2);
    apb(0, 0, 8'h0C, 32'h0, 4'h0, 0, 0, 32'h2, 0, "rc_rd2");
    cmp("rc_after2", 256'(r0(3)), 256'h0);
    apb(0, 1, 8'h0C, 32'hFF, 4'hF, 0, 0, 32'h0, 0, "rc_wr");
    cmp("rc_wr_ignored", 256'(r0(3)), 256'h0);

    // RO, W1S, WO
    apb(0, 0, 8'h10, 32'h0, 4'h0, 0, 0, 32'hCAFE_F00D, 0, "ro_rd");
    apb(0, 1, 8'h14, 32'h3, 4'hF, 0, 0, 32'h0, 0, "w1s_a");
    apb(0, 1, 8'h14, 32'hC, 4'hF, 0, 0, 32'h0, 0, "w1s_b");
    apb(0, 0, 8'h14, 32'h0, 4'h0, 0, 0, 32'hF, 0, "w1s_rd");
    apb(0, 1, 8'h18, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0, 0, "wo_wr");
    apb(0, 0, 8'h18, 32'h0, 4'h0, 0, 0, 32'h0, 0, "wo_rd");
    cmp("wo_out", 256'(r0(6)), 256'hDEAD_BEEF);

    // Three wait states: errors and normal traffic
    apb(1, 0, 8'h20, 32'h0, 4'h0, 0, 0, 32'h0, 1, "rd_oob");
    apb(1, 1, 8'h10, 32'hFFFF_FFFF, 4'hF, 0, 0, 32'h0, 1, "wr_ro");
    cmp("ro_unchanged", 256'(r3(4)), 256'h0);
    apb(1, 1, 8'h02, 32'hFFFF_FFFF, 4'hF, 0, 0, 32'h0, 1, "wr_unaligned");
    cmp("unaligned_nochg", 256'(r3(0)), 256'h0);
    apb(1, 1, 8'h1C, 32'h1122_3344, 4'hF, 0, 0, 32'h0, 0, "ws_wr7");
    apb(1, 0, 8'h1C, 32'h0, 4'h0, 0, 0, 32'h1122_3344, 0, "ws_rd7");

    // Abort by dropping psel during WAIT
    paddr = 8'h1C; pwrite = 1'b1; pwdata = 32'h55; pstrb = 4'hF; penable = 1'b0; psel3 = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1;
    cmp("abort_pready_low", 256'(pready3), 256'h0);
    @(posedge clk); #1;
    psel3 = 1'b0; penable = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    cmp("abort_nochg", 256'(r3(7)), 256'h1122_3344);
    cmp("abort_pready", 256'(pready3), 256'h0);
    apb(1, 0, 8'h1C, 32'h0, 4'h0, 0, 0, 32'h1122_3344, 0, "after_abort");

    // Reset during WAIT of a write
    paddr = 8'h1C; pwrite = 1'b1; pwdata = 32'h99; pstrb = 4'hF; penable = 1'b0; psel3 = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    cmp("rst_mid_regs", reg_out3, RV);
    cmp("rst_mid_pready", 256'(pready3), 256'h0);
    cmp("rst_mid_prdata", 256'(prdata3), 256'h0);
    @(posedge clk); #1;
    psel3 = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmp("rst_mid_reg7", 256'(r3(7)), 256'h0);
    apb(1, 0, 8'h04, 32'h0, 4'h0, 0, 0, 32'h1234_5678, 0, "after_rst");

    repeat (3) @(posedge clk);
    #1;
    cmp("queue_drained", 256'(q.size()), 256'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_regfile_gen.md
Name: apb_regfile_gen

Overview:
- Parametrised APB3 slave register file, the next generation of the team's fixed five-register APB regfile.
- Adds:
  - configurable register count, width and per-register access mode
  - byte strobes
  - programmable wait states
  - real address decode with pslverr
  - hardware set/status inputs
  - read-clear registers
  - an interrupt output
- Sits between the APB interconnect and a peripheral core. Software-visible control/status for that core.

Parameters:
- ADDR_W, 8, paddr width; register i lives at byte address 4*i.
- DATA_W, 32, register/bus width; 8, 16 or 32.
- NUM_REGS, 8, number of registers, 1..2^(ADDR_W-2).
- WAIT_STATES, 0, access-phase cycles with pready low before completion, 0..15.
- REG_MODES, all 0, packed NUM_REGS*3 bits, field i = mode of register i:
  - 0 RW
  - 1 RO (reads hw_in)
  - 2 W1C
  - 3 W1S
  - 4 WO
  - 5 RC (read-clear)
- RESET_VALS, all 0, packed NUM_REGS*DATA_W reset values.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- paddr  in  ADDR_W  APB address.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  1 = write.
- pwdata  in  DATA_W  write data.
- pstrb  in  DATA_W/8  byte write strobes.
- prdata  out  DATA_W  read data, registered.
- pready  out  1  transfer complete, registered.
- pslverr  out  1  transfer error, registered, valid with pready.
- hw_in  in  NUM_REGS*DATA_W  status values for RO registers.
- hw_set  in  NUM_REGS*DATA_W  per-bit set pulses for W1C/RC registers.
- reg_out  out  NUM_REGS*DATA_W  current register contents to the core.
- irq  out  1  OR of all bits of all W1C and RC registers, registered.

Behaviour:
- Reset (rst_n asynchronous, active-low; clock clk):
  - registers = RESET_VALS
  - prdata = 0, pready = 0, pslverr = 0, irq = 0
  - FSM in IDLE, wait counter = 0
- FSM states: IDLE, WAIT, ACK.
  - IDLE: setup phase detected (psel && !penable) → WAIT_STATES==0 ? ACK : WAIT, with cnt = WAIT_STATES-1.
  - WAIT: pready=0; psel low → IDLE (abort, no side effects); cnt==0 → ACK, else cnt--.
  - ACK: pready=1 for exactly one cycle → IDLE. A back-to-back setup in the following cycle is accepted from IDLE.
- Latency: pready rises in access cycle WAIT_STATES+1 after setup. Zero wait states → pready high in the first access cycle.
- Decode: idx = paddr[ADDR_W-1:2]. Error when:
  - idx >= NUM_REGS, or
  - paddr[1:0] != 0, or
  - write to an RO register.
- Error handling: pslverr=1 with pready; no register changes; prdata=0.
- prdata/pslverr load on the edge entering ACK:
  - read data = register value (RO: hw_in sampled at that edge)
  - WO reads 0
  - writes return prdata=0
- Write effects commit at the end of the ACK cycle, per enabled byte lane only:
  - RW/WO: lane = pwdata
  - W1S: reg |= pwdata
  - W1C: reg &= ~pwdata
  - RC: writes ignored, no error
- RC: at the end of a read ACK, clears exactly the bits captured in prdata. Bits set by hw_set after capture survive.
- hw_set priority:
  - W1C/RC: reg |= hw_set every cycle.
  - hw_set wins over a same-cycle software clear or read-clear on the same bit.
  - hw_set on RW/W1S/WO/RO registers is ignored.
- irq updates one cycle after the register change.
- Reset mid-transfer: immediate return to reset state; in-flight write discarded.

Test Plan:
- WAIT_STATES=0: write 0xA5A5_5A5A to reg0 (RW), pstrb=4'hF, then read → pready high first access cycle, prdata=0xA5A5_5A5A, pslverr=0.
- pstrb=4'b0010, pwdata=0x0000_FF00 to RW reg holding 0x1234_5678 → reg becomes 0x1234_FF78.
- W1C reg: hw_set bit3 pulse → irq=1 next cycle. Write 0x8 with simultaneous hw_set bit3 → bit stays 1. Write 0x8 alone → reg=0, irq=0.
- RC reg holding 0x5: read → prdata=0x5; hw_set bit1 during ACK → reg=0x2 after read.
- Errors, WAIT_STATES=3: read idx=NUM_REGS → pready after 3 low cycles, pslverr=1, prdata=0. Write RO reg → pslverr=1, no change. paddr=0x02 → pslverr=1.
- psel dropped in WAIT, and rst_n asserted in WAIT mid-write → no register change, FSM IDLE, pready=0.
